cla_sub_pipe: RTL and testbench
===============================

// Module: cla_sub_pipe
// PURPOSE
//  Pipelined two's-complement subtractor (add/sub selectable) built from 4-bit carry-look-ahead groups.
//  Computes a-b as a+~b+1; one 4-bit CLA group per pipeline stage, with the group carry registered into the next stage.
//  Sits downstream of the 4-bit CLA adder datapath; provides the subtract/compare direction with valid/ready flow control.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of 4 and >= 8
//  STAGES  WIDTH/4 (derived localparam, not overridable): pipeline depth, one stage per 4-bit group
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      block accepts beat this cycle
//  in_a       in   WIDTH  minuend (or addend)
//  in_b       in   WIDTH  subtrahend (or addend)
//  in_sub     in   1      1 = a-b, 0 = a+b
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  out_res    out  WIDTH  difference/sum
//  out_cb     out  1      sub: borrow (1 iff a<b unsigned); add: carry-out
//  out_ovf    out  1      signed overflow
//  out_zero   out  1      out_res == 0
// BEHAVIOUR
//  - Reset (async, immediate): all stage valid bits 0, all data/carry regs 0; out_valid=0, out_res=0, out_cb=0, out_ovf=0, out_zero=1.
//  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
//  - Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational, no dependence on in_valid).
//  - When adv=1 every stage shifts one position; stage 0 captures input (valid = in_valid). When adv=0 all stages hold.
//  - Bubbles are NOT compressed; a stall freezes the whole pipe.
//  - Stage k (0..STAGES-1): 4-bit CLA on group k of a and b' (b' = in_sub ? ~b : b):
//    p=a^b', g=a&b', c1=g0|p0c0, c2=g1|p1g0|p1p0c0, c3=..., c4=group carry-out; sum=p^{c3,c2,c1,c0}.
//  - c0 of stage 0 = in_sub; c0 of stage k>0 = registered c4 of stage k-1 for the same beat.
//  - Operand groups k>0 are delayed k cycles in skew registers; result groups k<STAGES-1 are delayed
//    (STAGES-1-k) cycles in deskew registers, so out_res is a coherent beat.
//  - Latency: exactly STAGES cycles from input transfer to out_valid with no stalls (4 for WIDTH=16).
//    Throughput: 1 beat/cycle while out_ready=1.
//  - Final flags: cout = c4 of last stage; out_cb = in_sub ? ~cout : cout (in_sub carried down the pipe with the beat);
//    out_ovf = c3 ^ c4 of last stage; out_zero = ~|out_res.
//  - Outputs registered; stable while out_valid && !out_ready.
//  - Simultaneous in/out transfer on a full pipe: allowed, no loss (adv=1 when out_ready=1).
//  - Wrap: results are modulo 2^WIDTH (0x0000-0x0001 -> 0xFFFF). No saturation.
//  - Reset mid-operation: all in-flight beats discarded; first beat after reset deassertion appears STAGES cycles after its transfer.
//  - Sub with b=0: cout=1 -> out_cb=0. Sub a==b: out_res=0, out_zero=1, out_cb=0.
// TESTING (WIDTH=16)
//  1. sub 0x1234-0x0234, out_ready=1 -> 4 cycles later out_res=0x1000, cb=0, ovf=0, zero=0.
//  2. sub 0x0000-0x0001 -> 0xFFFF, cb=1, ovf=0; sub 0x8000-0x0001 -> 0x7FFF, cb=0, ovf=1.
//  3. add 0xFFFF+0x0001 -> 0x0000, cb=1, zero=1, ovf=0; add 0x7FFF+0x0001 -> 0x8000, ovf=1, cb=0.
//  4. 8 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, all 8 results in order, none lost/duplicated.
//  5. rst pulsed (async, between edges) with 3 beats in flight -> out_valid=0 immediately, no stale beat emerges afterwards.
//  6. 10k random a,b,sub with random out_ready -> every result matches a-b / a+b mod 2^16 and flag model.

Source files
------------

// File: rtl/cla_sub_pipe.sv
// Pipelined add/subtract unit built from one 4-bit carry-look-ahead group per stage.
// Operand groups are skewed into their stage, result groups are deskewed to form a coherent beat.
module cla_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cb,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_sub_pipe: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef struct packed {
    logic [3:0] sum;
    logic       c4;
  } cla4_t;

  // Flat two-level look-ahead: every carry is a direct sum of products of g, p and c0.
  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    cla4_t      o;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    o.sum = p ^ c[3:0];
    o.c4  = c[4];
    return o;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // The whole pipe moves or holds as one; a full pipe still advances when the consumer takes a beat.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = in_sub ? ~in_b : in_b;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int RW = 4 * (k + 1);
    localparam int SW = WIDTH - RW;

    logic [3:0]    ga;
    logic [3:0]    gb;
    logic          cin;
    logic          v_in;
    logic          sub_in;
    logic [RW-1:0] r_in;
    cla4_t         cl;

    logic          v_q;
    logic          sub_q;
    logic          c4_q;
    logic [RW-1:0] r_q;

    if (k == 0) begin : g_src
      assign ga     = in_a[3:0];
      assign gb     = b_eff[3:0];
      assign cin    = in_sub;
      assign v_in   = in_valid;
      assign sub_in = in_sub;
      assign r_in   = cl.sum;
    end else begin : g_src
      assign ga     = stg[k-1].g_skew.a_q[3:0];
      assign gb     = stg[k-1].g_skew.b_q[3:0];
      assign cin    = stg[k-1].c4_q;
      assign v_in   = stg[k-1].v_q;
      assign sub_in = stg[k-1].sub_q;
      assign r_in   = {cl.sum, stg[k-1].r_q};
    end

    assign cl = cla4(ga, gb, cin);

    // NOTE: state is updated with non-blocking assignments so every stage samples its
    // predecessor's value from before the edge; blocking here would let a beat race through.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        sub_q <= 1'b0;
        c4_q  <= 1'b0;
        r_q   <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        sub_q <= sub_in;
        c4_q  <= cl.c4;
        r_q   <= r_in;
      end
    end

    // Operand groups not yet consumed ride along with the beat.
    if (k < STAGES - 1) begin : g_skew
      logic [SW-1:0] a_q;
      logic [SW-1:0] b_q;
      logic [SW-1:0] a_nx;
      logic [SW-1:0] b_nx;

      if (k == 0) begin : g_nx
        assign a_nx = in_a[WIDTH-1:4];
        assign b_nx = b_eff[WIDTH-1:4];
      end else begin : g_nx
        assign a_nx = stg[k-1].g_skew.a_q[SW+3:4];
        assign b_nx = stg[k-1].g_skew.b_q[SW+3:4];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end else begin : g_last
      // Carry into the sign bit is recovered as p3 ^ sum3, so overflow is c3 ^ c4.
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ga[3] ^ gb[3] ^ cl.sum[3] ^ cl.c4;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].v_q;
  assign out_res   = stg[STAGES-1].r_q;
  assign out_cb    = stg[STAGES-1].c4_q ^ stg[STAGES-1].sub_q;
  assign out_ovf   = stg[STAGES-1].g_last.ovf_q;
  assign out_zero  = ~|out_res;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed and randomised checks of cla_sub_pipe at WIDTH=16: values, flags, latency,
// back-pressure, asynchronous reset flush.
module tb_cla_sub_pipe;

  localparam int W  = 16;
  localparam int ST = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_cb;
  logic         out_ovf;
  logic         out_zero;

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_cb   (out_cb),
    .out_ovf  (out_ovf),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cb;
    logic         ovf;
    logic         zero;
  } exp_t;

  typedef struct packed {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  vec_t   vecs[16];
  exp_t   q[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad   = 0;
  int     nout  = 0;
  bit     rnd_ready = 1'b0;
  logic   hold_v = 1'b0;
  logic [W-1:0] hold_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic cb, input logic ovf,
                              input logic zero);
    vec_t v;
    v.sub = s; v.a = a; v.b = b;
    v.e.res = res; v.e.cb = cb; v.e.ovf = ovf; v.e.zero = zero;
    return v;
  endfunction

  // Reference arithmetic for random beats: plain wide add/subtract and sign rules.
  function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] t;
    if (s) begin
      t     = {1'b0, a} - {1'b0, b};
      e.cb  = (a < b);
      e.ovf = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
    end else begin
      t     = {1'b0, a} + {1'b0, b};
      e.cb  = t[W];
      e.ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    end
    e.res  = t[W-1:0];
    e.zero = (t[W-1:0] == '0);
    return e;
  endfunction

  // Output monitor: in-order scoreboard plus hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) check("hold_res", out_res, hold_res);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_beat", out_valid, 1'b0);
        end else begin
          mon_e = q.pop_front();
          check("res",  out_res,  mon_e.res);
          check("cb",   out_cb,   mon_e.cb);
          check("ovf",  out_ovf,  mon_e.ovf);
          check("zero", out_zero, mon_e.zero);
          nout++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_res;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Offers one beat starting at posedge+1; returns at posedge+1 after its transfer edge.
  task automatic put(input vec_t v);
    in_valid = 1'b1; in_sub = v.sub; in_a = v.a; in_b = v.b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(v.e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    check("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 400 && q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(tag, q.size(), 0);
  endtask

  // Counts rising edges from the transfer edge (edge 1) until out_valid is seen.
  task automatic latency_test(input vec_t v, input string tag);
    int n;
    bit seen;
    out_ready = 1'b1;
    put(v);
    n = 1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check(tag, n, ST);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nout0;
    int nv;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    vecs[0]  = mk(1'b1, 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
    vecs[12] = mk(1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_res",   out_res,   '0);
    check("rst_out_cb",    out_cb,    1'b0);
    check("rst_out_ovf",   out_ovf,   1'b0);
    check("rst_out_zero",  out_zero,  1'b1);
    check("rst_in_ready",  in_ready,  1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency and value of the first subtract, then the spec corner vectors back-to-back
    latency_test(vecs[0], "latency");
    for (int i = 1; i < 8; i++) put(vecs[i]);
    drain("drain_directed");

    // Back-pressure mid-stream: three cycles of out_ready low
    nout0 = nout;
    fork
      begin
        for (int i = 8; i < 16; i++) put(vecs[i]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  in_ready,  1'b0);
          check("stall_out_valid", out_valid, 1'b1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    check("stall_count", nout - nout0, 8);

    // Asynchronous reset between edges with beats in flight
    for (int i = 0; i < 5; i++) put(vecs[i]);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_res",   out_res,   '0);
    check("arst_out_zero",  out_zero,  1'b1);
    check("arst_in_ready",  in_ready,  1'b1);
    q.delete();
    #1 rst = 1'b0;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("no_stale_beat", nv, 0);
    @(posedge clk);
    #1;
    latency_test(vecs[6], "latency_after_rst");

    // Random operands with random consumer back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = (i % 16 == 0) ? ra : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      put(mk(rs, ra, rb, model(rs, ra, rb).res, model(rs, ra, rb).cb,
             model(rs, ra, rb).ovf, model(rs, ra, rb).zero));
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
